// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR beat aligner.
// Holds the control FSM states and the lane-mask helper.
package csr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int MAX_LANES = 64;

    // Thermometer mask: lane i set while i < min(rem, lanes)
    function automatic logic [MAX_LANES-1:0] lane_mask(
        input logic [63:0] rem,
        input int          lanes
    );
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes && rem > 64'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Valid/ready stream bundle with a last marker.
// Master drives payload; slave returns ready.
interface axi_stream_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic             last;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/csr_skid_buffer.sv
// Two-entry registered skid buffer.
// Input ready is a register driven only by occupancy.
module csr_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       cnt;
    logic [1:0]       cnt_n;
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             push;
    logic             pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = ent0;

    // Next occupancy from this cycle's push and pop
    always_comb begin
        cnt_n = cnt + {1'b0, push} - {1'b0, pop};
    end

    // Entry 0 always feeds the output; entry 1 is the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            ent0      <= '0;
            ent1      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (pop) begin
                if (cnt == 2'd2) begin
                    ent0 <= ent1;
                end else if (push) begin
                    ent0 <= in_data;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    ent0 <= in_data;
                end else begin
                    ent1 <= in_data;
                end
            end
            cnt       <= cnt_n;
            out_valid <= (cnt_n != 2'd0);
            in_ready  <= (cnt_n != 2'd2);
        end
    end

endmodule

// File: rtl/csr_beat_aligner.sv
// Joins row/column/value CSR streams into lane-aligned beats.
// The programmed non-zero count frames the matrix.
module csr_beat_aligner
    import csr_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int ROW_WIDTH = 32,
    parameter int IDX_WIDTH = 32,
    parameter int VAL_WIDTH = 32,
    parameter int NNZ_WIDTH = 32,
    parameter int ZERO_PAD  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NNZ_WIDTH-1:0]       nnz,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    axi_stream_if.slave                r_idx_s,
    axi_stream_if.slave                c_idx_s,
    axi_stream_if.slave                c_val_s,
    output logic [LANES*ROW_WIDTH-1:0] r_idx,
    output logic [LANES*IDX_WIDTH-1:0] c_idx,
    output logic [LANES*VAL_WIDTH-1:0] val,
    output logic [LANES-1:0]           mask,
    output logic                       valid,
    input  logic                       ready,
    output logic                       last
);

    localparam int PW = LANES * (ROW_WIDTH + IDX_WIDTH + VAL_WIDTH)
                        + LANES + 1;

    state_t                     state;
    logic [NNZ_WIDTH-1:0]       remaining;
    logic                       all_v;
    logic                       any_last;
    logic                       all_last;
    logic                       fin;
    logic                       sk_in_valid;
    logic                       sk_in_ready;
    logic                       join_fire;
    logic [LANES-1:0]           j_mask;
    logic [LANES*ROW_WIDTH-1:0] r_p;
    logic [LANES*IDX_WIDTH-1:0] c_p;
    logic [LANES*VAL_WIDTH-1:0] v_p;
    logic [PW-1:0]              sk_out;

    assign all_v    = r_idx_s.valid && c_idx_s.valid && c_val_s.valid;
    assign any_last = r_idx_s.last || c_idx_s.last || c_val_s.last;
    assign all_last = r_idx_s.last && c_idx_s.last && c_val_s.last;
    assign fin      = remaining <= NNZ_WIDTH'(LANES);
    assign j_mask   = LANES'(lane_mask(64'(remaining), LANES));

    assign sk_in_valid = (state == RUN) && all_v;
    assign join_fire   = sk_in_valid && sk_in_ready;

    assign r_idx_s.ready = join_fire;
    assign c_idx_s.ready = join_fire;
    assign c_val_s.ready = join_fire;

    assign busy = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_pad
        logic keep;
        assign keep = j_mask[g] || (ZERO_PAD == 0);
        assign r_p[g*ROW_WIDTH +: ROW_WIDTH] =
            keep ? r_idx_s.data[g*ROW_WIDTH +: ROW_WIDTH] : '0;
        assign c_p[g*IDX_WIDTH +: IDX_WIDTH] =
            keep ? c_idx_s.data[g*IDX_WIDTH +: IDX_WIDTH] : '0;
        assign v_p[g*VAL_WIDTH +: VAL_WIDTH] =
            keep ? c_val_s.data[g*VAL_WIDTH +: VAL_WIDTH] : '0;
    end

    csr_skid_buffer #(
        .WIDTH (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sk_in_valid),
        .in_ready  (sk_in_ready),
        .in_data   ({r_p, c_p, v_p, j_mask, fin}),
        .out_valid (valid),
        .out_ready (ready),
        .out_data  (sk_out)
    );

    assign {r_idx, c_idx, val, mask, last} = sk_out;

    // Matrix framing, length-mismatch detection and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (nnz != '0) begin
                            remaining <= nnz;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (join_fire) begin
                        if (fin) begin
                            remaining <= '0;
                            state     <= DRAIN;
                            if (!all_last) begin
                                err <= 1'b1;
                            end
                        end else begin
                            remaining <= remaining - NNZ_WIDTH'(LANES);
                            if (any_last) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (valid && ready && last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_beat_aligner.sv
// Scoreboard bench for csr_beat_aligner, ZERO_PAD=1 and =0 side by side.
// Both copies see identical stimulus and backpressure.
module tb_csr_beat_aligner;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int DW = L * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [31:0] nnz;
    logic        rdy_mode;
    logic        rdy_val;
    logic        rnd_bit;
    logic        abort;
    wire         ready = rdy_mode ? rnd_bit : rdy_val;

    logic          sv   [3];
    logic [DW-1:0] sd   [3];
    logic          sl   [3];
    logic          srdy [3];

    axi_stream_if #(.WIDTH(DW)) r_if ();
    axi_stream_if #(.WIDTH(DW)) c_if ();
    axi_stream_if #(.WIDTH(DW)) v_if ();
    axi_stream_if #(.WIDTH(DW)) r0_if ();
    axi_stream_if #(.WIDTH(DW)) c0_if ();
    axi_stream_if #(.WIDTH(DW)) v0_if ();

    assign r_if.valid = sv[0];
    assign r_if.data  = sd[0];
    assign r_if.last  = sl[0];
    assign c_if.valid = sv[1];
    assign c_if.data  = sd[1];
    assign c_if.last  = sl[1];
    assign v_if.valid = sv[2];
    assign v_if.data  = sd[2];
    assign v_if.last  = sl[2];
    assign r0_if.valid = sv[0];
    assign r0_if.data  = sd[0];
    assign r0_if.last  = sl[0];
    assign c0_if.valid = sv[1];
    assign c0_if.data  = sd[1];
    assign c0_if.last  = sl[1];
    assign v0_if.valid = sv[2];
    assign v0_if.data  = sd[2];
    assign v0_if.last  = sl[2];
    assign srdy[0] = r_if.ready;
    assign srdy[1] = c_if.ready;
    assign srdy[2] = v_if.ready;

    logic          busy, done, err, o_valid, o_last;
    logic [DW-1:0] o_r, o_c, o_v;
    logic [L-1:0]  o_m;
    logic          z_busy, z_done, z_err, z_valid, z_last;
    logic [DW-1:0] z_r, z_c, z_v;
    logic [L-1:0]  z_m;

    csr_beat_aligner #(
        .LANES(L), .ROW_WIDTH(W), .IDX_WIDTH(W), .VAL_WIDTH(W),
        .NNZ_WIDTH(32), .ZERO_PAD(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nnz(nnz),
        .busy(busy), .done(done), .err(err),
        .r_idx_s(r_if), .c_idx_s(c_if), .c_val_s(v_if),
        .r_idx(o_r), .c_idx(o_c), .val(o_v), .mask(o_m),
        .valid(o_valid), .ready(ready), .last(o_last)
    );

    csr_beat_aligner #(
        .LANES(L), .ROW_WIDTH(W), .IDX_WIDTH(W), .VAL_WIDTH(W),
        .NNZ_WIDTH(32), .ZERO_PAD(0)
    ) dut_raw (
        .clk(clk), .rst_n(rst_n), .start(start), .nnz(nnz),
        .busy(z_busy), .done(z_done), .err(z_err),
        .r_idx_s(r0_if), .c_idx_s(c0_if), .c_val_s(v0_if),
        .r_idx(z_r), .c_idx(z_c), .val(z_v), .mask(z_m),
        .valid(z_valid), .ready(ready), .last(z_last)
    );

    always @(posedge clk) rnd_bit <= 1'($urandom_range(1));

    typedef struct {
        logic [DW-1:0] r, c, v;
        logic [DW-1:0] zr, zc, zv;
        logic [L-1:0]  m;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   occ    = 0;
    logic stalled = 1'b0;
    logic [3*DW+L:0] held;
    time  last_hs_t = 0;

    function automatic logic [DW-1:0] bdata(input int s, input int k);
        logic [DW-1:0] d;
        for (int i = 0; i < L; i++)
            d[i*W +: W] = W'((s + 1) * 32'h0100_0000 + k * 32'h0001_0000
                             + 32'hA000 + i);
        return d;
    endfunction

    function automatic logic [DW-1:0] pad(input logic [DW-1:0] d,
                                          input logic [L-1:0] m);
        logic [DW-1:0] o;
        o = d;
        for (int i = 0; i < L; i++)
            if (!m[i]) o[i*W +: W] = '0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic push_beat(input int k, input logic [L-1:0] m,
                             input logic l);
        exp_t e;
        e.zr = bdata(0, k);
        e.zc = bdata(1, k);
        e.zv = bdata(2, k);
        e.r  = pad(e.zr, m);
        e.c  = pad(e.zc, m);
        e.v  = pad(e.zv, m);
        e.m  = m;
        e.l  = l;
        q.push_back(e);
    endtask

    // Output monitor: scoreboard pop, stall stability, occupancy bound
    always @(negedge clk) begin
        exp_t e;
        logic jn, hs;
        if (!rst_n) begin
            occ     = 0;
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_stable",
                    64'(o_valid && held === {o_r, o_c, o_v, o_m, o_last}), 1);
            jn = sv[0] && sv[1] && sv[2] && srdy[0];
            hs = o_valid && ready;
            occ = occ + int'(jn) - int'(hs);
            if (jn) chk("occupancy_le2", 64'(occ <= 2), 1);
            if (hs) begin
                stalled = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(q.size()), 1);
                end else begin
                    e = q.pop_front();
                    chk("beat_mask", 64'(o_m), 64'(e.m));
                    chk("beat_last", 64'(o_last), 64'(e.l));
                    chk("beat_data_pad",
                        64'({o_r, o_c, o_v} === {e.r, e.c, e.v}), 1);
                    chk("raw_valid", 64'(z_valid), 1);
                    chk("beat_data_raw",
                        64'({z_r, z_c, z_v, z_m, z_last}
                            === {e.zr, e.zc, e.zv, e.m, e.l}), 1);
                    if (e.l) last_hs_t = $time;
                end
            end else if (o_valid) begin
                stalled = 1'b1;
                held    = {o_r, o_c, o_v, o_m, o_last};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input int s, input int nb, input int gap,
                        input int bad);
        for (int k = 0; k < nb && !abort; k++) begin
            logic acc;
            if (gap > 0) begin
                repeat ($urandom_range(gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            sv[s] = 1'b1;
            sd[s] = bdata(s, k);
            sl[s] = (k == nb - 1) ^ (k == bad);
            acc = 1'b0;
            for (int t = 0; t < 2000 && !acc && !abort; t++) begin
                @(negedge clk);
                if (srdy[s]) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!abort) chk("input_accept", 64'(acc), 1);
            sv[s] = 1'b0;
        end
        sv[s] = 1'b0;
        sl[s] = 1'b0;
    endtask

    task automatic go(input int n, input int nb, input int gap,
                      input int bad);
        @(posedge clk);
        #1;
        start = 1'b1;
        nnz   = 32'(n);
        fork
            send(0, nb, gap, -1);
            send(1, nb, gap, bad);
            send(2, nb, gap, -1);
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                chk("busy_after_start", 64'(busy), 64'(n != 0));
                chk("err_cleared", 64'(err), 0);
            end
        join
    endtask

    task automatic wait_done(input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, 64'(got), 1);
        if (got) begin
            chk({nm, "_done_timing"}, 64'($time - last_hs_t), 10);
            @(negedge clk);
            chk({nm, "_done_pulse"}, 64'(done), 0);
            chk({nm, "_busy_idle"}, 64'(busy), 0);
            chk({nm, "_queue_empty"}, 64'(q.size()), 0);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0;
            sd[s] = '0;
            sl[s] = 1'b0;
        end
        rst_n    = 1'b0;
        start    = 1'b0;
        nnz      = '0;
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        abort    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_mask", 64'(o_m), 0);
        chk("rst_last", 64'(o_last), 0);
        chk("rst_in_ready", 64'(srdy[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // nnz=40, full rate
        push_beat(0, 16'hFFFF, 1'b0);
        push_beat(1, 16'hFFFF, 1'b0);
        push_beat(2, 16'h00FF, 1'b1);
        go(40, 3, 0, -1);
        wait_done("n40");
        chk("n40_err", 64'(err), 0);

        // nnz=16, single full beat
        push_beat(0, 16'hFFFF, 1'b1);
        go(16, 1, 0, -1);
        wait_done("n16");

        // nnz=0, done only
        @(posedge clk);
        #1;
        start = 1'b1;
        nnz   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("n0_done", 64'(done), 1);
        chk("n0_busy", 64'(busy), 0);
        chk("n0_valid", 64'(o_valid), 0);
        @(negedge clk);
        chk("n0_done_pulse", 64'(done), 0);

        // nnz=40, random gaps and backpressure
        rdy_mode = 1'b1;
        push_beat(0, 16'hFFFF, 1'b0);
        push_beat(1, 16'hFFFF, 1'b0);
        push_beat(2, 16'h00FF, 1'b1);
        go(40, 3, 4, -1);
        wait_done("rnd");
        rdy_mode = 1'b0;

        // c_idx last early on beat 2 of 3
        push_beat(0, 16'hFFFF, 1'b0);
        push_beat(1, 16'hFFFF, 1'b0);
        push_beat(2, 16'h00FF, 1'b1);
        go(40, 3, 0, 1);
        wait_done("err");
        chk("err_set", 64'(err), 1);

        // nnz=20, padded lanes 4-15 on beat 2
        push_beat(0, 16'hFFFF, 1'b0);
        push_beat(1, 16'h000F, 1'b1);
        go(20, 2, 0, -1);
        wait_done("n20");
        chk("n20_err", 64'(err), 0);

        // reset while beat 2 is stalled
        rdy_val = 1'b0;
        push_beat(0, 16'hFFFF, 1'b0);
        fork
            go(40, 3, 0, -1);
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (o_valid) seen = 1'b1;
                end
                chk("rst_test_valid_seen", 64'(seen), 1);
                rdy_val = 1'b1;
                @(posedge clk);
                #1;
                rdy_val = 1'b0;
                repeat (3) @(posedge clk);
                #3;
                abort = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", 64'(o_valid), 0);
                chk("midrst_busy", 64'(busy), 0);
                chk("midrst_mask", 64'(o_m), 0);
                chk("midrst_queue", 64'(q.size()), 0);
            end
        join
        q.delete();
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 64'(done), 0);
        rst_n   = 1'b1;
        abort   = 1'b0;
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        push_beat(0, 16'h00FF, 1'b1);
        go(8, 1, 0, -1);
        wait_done("n8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/csr_beat_aligner.md
# csr_beat_aligner

Joins the three per-lane CSR streams of a sparse-matrix read (decoded row indices, column indices, values) into one lane-aligned beat stream for the SpMV datapath. Generalises the current aligner:
- lane count and all field widths are parameters;
- a programmed non-zero count drives the end of stream, and padding lanes of the final beat are masked (optionally zeroed);
- a registered skid output sustains one beat per cycle under backpressure;
- stream-length mismatches are detected and flagged.

## Interface
Parameters:
- LANES, 16, elements per beat (one DDR word)
- ROW_WIDTH, 32, row-index width
- IDX_WIDTH, 32, column-index width
- VAL_WIDTH, 32, value width
- NNZ_WIDTH, 32, width of the non-zero count
- ZERO_PAD, 1, when 1 the masked lanes of the output data are driven to 0; when 0 they pass through unchanged

Ports (clock and reset first):
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; latches nnz and begins a matrix
- nnz  in  NNZ_WIDTH  total non-zeros in the matrix
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at end of matrix
- err  out  1  sticky length-mismatch flag; cleared by start
- r_idx_s  axi_stream_if.slave  LANES x ROW_WIDTH  row indices, padding already stripped
- c_idx_s  axi_stream_if.slave  LANES x IDX_WIDTH  column indices
- c_val_s  axi_stream_if.slave  LANES x VAL_WIDTH  values
- r_idx, c_idx, val  out  LANES x width  aligned beat data
- mask  out  LANES  lane i valid when bit i is set
- valid  out  1  beat valid
- ready  in  1  downstream ready
- last  out  1  final beat of the matrix

## Operation
State machine, reset state IDLE:
- **IDLE**
  - start with nnz>0: latch remaining=nnz, clear err, go to RUN.
  - start with nnz=0: pulse done the next cycle, stay in IDLE, emit no beats.
- **RUN**
  - A join fires when all three input valids are high and the skid buffer has space. The three input readys are asserted together only in that case.
  - On a join:
    - n = min(remaining, LANES);
    - mask = (1<<n)-1, a thermometer from lane 0;
    - last = (remaining <= LANES);
    - remaining -= n, computed at NNZ_WIDTH with no wrap possible.
  - After the last join, go to DRAIN.
- **DRAIN**
  - Inputs are not ready.
  - When the last beat completes its output handshake, pulse done and go to IDLE.
- busy = (state != IDLE).

Error detection (err is sticky):
- Any input last flag high on a join that is not the final join sets err.
- On the final join, any input last flag low sets err.
- Beats are still emitted unchanged when err is set; the count always governs framing.

Other rules:
- start while busy is ignored.
- With ZERO_PAD=1, data in lanes with mask=0 is forced to 0.

## Timing
- Reset: all outputs are 0; state IDLE; remaining 0; skid buffer empty.
- Latency: join to output valid is 1 cycle, because outputs come from registers.
- Throughput: 1 beat/cycle while ready is held high.
- Skid buffer: 2 entries.
  - The input-side ready is registered and depends only on buffer occupancy, never combinationally on the output ready.
  - Once valid is high, the output data, mask and last stay stable until ready.
- A join and an output handshake in the same cycle with the buffer full: the handshake frees the entry, and the join is accepted only if space existed at the start of the cycle.
- done is asserted the cycle after the output handshake of the last beat.
- A start in that same cycle is accepted, because the state is already IDLE.
- Reset asserted mid-matrix: beats in flight are dropped and all outputs clear immediately. No done pulse follows.

## Structure
- csr_pkg holds the state enum (IDLE/RUN/DRAIN) and a function computing the lane mask from the remaining count and LANES.
- One sub-module, csr_skid_buffer, parameterised on the packed payload width. Its payload is the concatenation of r_idx, c_idx, val, mask and last.

## Test plan
- LANES=16, nnz=40, inputs always valid, ready=1: 3 beats with masks FFFF, FFFF, 00FF; last only on beat 3; done 1 cycle after beat 3 handshake; err=0.
- nnz=16: a single beat with mask FFFF and last=1. nnz=0: done pulse 1 cycle after start, no valid, busy stays 0.
- nnz=40 with random output ready (50%) and random valid gaps on each input: data is in order and matches references; payload is stable while stalled; never more than 2 beats buffered.
- c_idx_s asserts last on beat 2 of 3: err=1 from that join; 3 beats still emitted; err clears on the next start.
- ZERO_PAD=1, nnz=20: beat 2 lanes 4-15 read 0 in all fields. ZERO_PAD=0: those lanes pass the input data through.
- rst_n dropped while beat 2 is stalled: valid, busy and mask go to 0 immediately. A fresh start with nnz=8 then yields one beat with mask 00FF.
